// File: rtl/cfg_seq_pkg.sv
// ---------------------------------------------------------------------------
// cfg_seq_pkg
// Shared definitions for the camera-sensor configuration sequencer:
//   - FSM state encoding (legacy-compatible localparam constants)
//   - bit-field positions inside a 24-bit LUT word {reg_addr, data}
//   - default delay / count constants used as parameter defaults
// ---------------------------------------------------------------------------
package cfg_seq_pkg;

    // Sequencer states
    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    // LUT word layout: {reg_addr[23:16], data[15:0]}
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;

    // Shared delay counter width (wide enough for the power-up delay)
    localparam int CNT_W = 24;

    // Defaults: 20 ms power-up at 50 MHz, 100-cycle inter-transaction gap
    localparam logic [23:0] DEF_INIT_DLY  = 24'd1_000_000;
    localparam logic [15:0] DEF_GAP_DLY   = 16'd100;
    localparam logic [7:0]  DEF_READ_NUM  = 8'd2;
    localparam logic [3:0]  DEF_MAX_RETRY = 4'd3;

endpackage

// File: rtl/cfg_delay_cnt.sv
// ---------------------------------------------------------------------------
// cfg_delay_cnt
// Loadable down-counter with a zero flag. One instance is shared by the
// power-up (INIT) and inter-transaction (GAP) delays; the sequencer reloads
// it on entry to each waiting state.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (loads RESET_VAL)
//   load        : load load_val this cycle (has priority over dec)
//   load_val    : value to load
//   dec         : decrement by one, saturating at zero
//   zero        : count is zero
// ---------------------------------------------------------------------------
module cfg_delay_cnt #(
    parameter int           W         = 24,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Counter register; reset value lets the sequencer start its
    // power-up wait straight out of reset without an extra load cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_cfg_sequencer
// Walks the sensor configuration LUT from index 0 to lut_size-1 and issues
// one I2C transaction per entry. The first READ_NUM entries are reads whose
// data is compared with the LUT value; the rest are register writes. A
// power-up delay precedes the first transfer and a fixed gap follows each
// transfer. NACKed transfers are retried up to MAX_RETRY times.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   cfg_start         : restart pulse, honoured only in DONE/ERR
//   lut_index/lut_data: LUT address out, {reg_addr, data} back (comb.)
//   lut_size          : number of valid LUT entries
//   i2c_req/rw/addr/wdata : request to the I2C master (held while req=1)
//   i2c_done/nack/rdata   : completion pulse and status from the master
//   cfg_busy          : sequence in progress
//   cfg_done/cfg_err  : sticky completion / abort flags
//   id_mismatch       : sticky, a read returned unexpected data
// ---------------------------------------------------------------------------
module i2c_cfg_sequencer
    import cfg_seq_pkg::*;
#(
    parameter logic [23:0] INIT_DLY  = DEF_INIT_DLY,
    parameter logic [15:0] GAP_DLY   = DEF_GAP_DLY,
    parameter logic [7:0]  READ_NUM  = DEF_READ_NUM,
    parameter logic [3:0]  MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    output logic [7:0]  lut_index,
    input  logic [23:0] lut_data,
    input  logic [7:0]  lut_size,
    output logic        i2c_req,
    output logic        i2c_rw,
    output logic [7:0]  i2c_addr,
    output logic [15:0] i2c_wdata,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    input  logic [15:0] i2c_rdata,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        id_mismatch
);

    // Counter reload values: a wait of N cycles runs N-1 down to 0
    localparam logic [CNT_W-1:0] INIT_RELOAD = INIT_DLY - 24'd1;
    localparam logic [CNT_W-1:0] GAP_RELOAD  = {8'd0, GAP_DLY} - 24'd1;

    logic [2:0]       state;
    logic [3:0]       retry_cnt;
    logic             last_ok;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    cfg_delay_cnt #(
        .W         (CNT_W),
        .RESET_VAL (INIT_RELOAD)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Delay counter control: reload on entry to GAP (any transfer that does
    // not abort) and on a restart into INIT; count down while waiting.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = INIT_RELOAD;
        case (state)
            ST_INIT: cnt_dec = !cnt_zero;
            ST_GAP:  cnt_dec = !cnt_zero;
            ST_REQ: begin
                if (i2c_done && (!i2c_nack || (retry_cnt < MAX_RETRY))) begin
                    cnt_load = 1'b1;
                    cnt_val  = GAP_RELOAD;
                end
            end
            ST_DONE, ST_ERR: cnt_load = cfg_start;
            default: ;
        endcase
    end

    // Main sequencer FSM and registered outputs. last_ok remembers whether
    // the transfer before GAP succeeded, so a NACK reissues the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            lut_index   <= 8'd0;
            i2c_req     <= 1'b0;
            i2c_rw      <= 1'b0;
            i2c_addr    <= 8'd0;
            i2c_wdata   <= 16'd0;
            cfg_busy    <= 1'b0;
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
            id_mismatch <= 1'b0;
            retry_cnt   <= 4'd0;
            last_ok     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    cfg_busy <= 1'b1;
                    if (cnt_zero) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (lut_index >= lut_size) begin
                        state    <= ST_DONE;
                        cfg_done <= 1'b1;
                        cfg_busy <= 1'b0;
                    end else begin
                        i2c_addr  <= lut_data[ADDR_MSB:ADDR_LSB];
                        i2c_wdata <= lut_data[DATA_MSB:0];
                        i2c_rw    <= (lut_index < READ_NUM);
                        i2c_req   <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i2c_done) begin
                        i2c_req <= 1'b0;
                        if (!i2c_nack) begin
                            // For reads, i2c_wdata still holds the expected value
                            if (i2c_rw && (i2c_rdata != i2c_wdata)) begin
                                id_mismatch <= 1'b1;
                            end
                            retry_cnt <= 4'd0;
                            last_ok   <= 1'b1;
                            state     <= ST_GAP;
                        end else if (retry_cnt < MAX_RETRY) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            last_ok   <= 1'b0;
                            state     <= ST_GAP;
                        end else begin
                            state    <= ST_ERR;
                            cfg_err  <= 1'b1;
                            cfg_busy <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        if (last_ok) begin
                            lut_index <= lut_index + 8'd1;
                        end
                        state <= ST_LOAD;
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (cfg_start) begin
                        state       <= ST_INIT;
                        lut_index   <= 8'd0;
                        cfg_done    <= 1'b0;
                        cfg_err     <= 1'b0;
                        id_mismatch <= 1'b0;
                        retry_cnt   <= 4'd0;
                        cfg_busy    <= 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_cfg_sequencer
// Self-checking bench for i2c_cfg_sequencer. An I2C slave model answers each
// request after a random latency according to a per-entry plan (number of
// NACKs, good or bad read data). A reference model expands the plan into the
// list of transactions the sequencer must issue and its final flags.
// Cycle numbering: the period before the first rising edge after reset
// release (or after the edge that samples cfg_start) is cycle 1.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_cfg_sequencer;

    localparam int INIT_I = 10;
    localparam int GAP_I  = 4;
    localparam int RN_I   = 2;
    localparam int MR_I   = 3;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic [7:0]  lut_index;
    logic [23:0] lut_data;
    logic [7:0]  lut_size;
    logic        i2c_req;
    logic        i2c_rw;
    logic [7:0]  i2c_addr;
    logic [15:0] i2c_wdata;
    logic        i2c_done;
    logic        i2c_nack;
    logic [15:0] i2c_rdata;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic        id_mismatch;

    logic [23:0] lut_mem [256];
    assign lut_data = lut_mem[lut_index];

    i2c_cfg_sequencer #(
        .INIT_DLY  (24'd10),
        .GAP_DLY   (16'd4),
        .READ_NUM  (8'd2),
        .MAX_RETRY (4'd3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_start   (cfg_start),
        .lut_index   (lut_index),
        .lut_data    (lut_data),
        .lut_size    (lut_size),
        .i2c_req     (i2c_req),
        .i2c_rw      (i2c_rw),
        .i2c_addr    (i2c_addr),
        .i2c_wdata   (i2c_wdata),
        .i2c_done    (i2c_done),
        .i2c_nack    (i2c_nack),
        .i2c_rdata   (i2c_rdata),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .id_mismatch (id_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        rw;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    int          nack_plan [256];
    bit          bad_plan  [256];
    logic [15:0] bad_val   [256];
    int          tries     [256];
    bit          exp_done, exp_err, exp_mism;
    int          exp_index, exp_total;
    int          checks = 0;
    int          errors = 0;
    int          cyc, base_cyc, rise_base, done_rise_cyc;
    int          rise_times[$];
    bit          stray_en;
    bit          mon_prev, mon_has_prev, mon_dprev;
    int          mon_low;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model: expand the slave plan into the expected transaction list
    task automatic buildModel(input int size);
        exp_q.delete();
        exp_err   = 1'b0;
        exp_mism  = 1'b0;
        exp_index = size;
        for (int i = 0; i < size; i++) begin
            int attempts;
            bit fails;
            fails    = nack_plan[i] > MR_I;
            attempts = fails ? MR_I + 1 : nack_plan[i] + 1;
            for (int a = 0; a < attempts; a++) begin
                txn_t t;
                t.idx   = i;
                t.rw    = (i < RN_I);
                t.addr  = lut_mem[i][23:16];
                t.wdata = lut_mem[i][15:0];
                exp_q.push_back(t);
            end
            if (fails) begin
                exp_err   = 1'b1;
                exp_index = i;
                break;
            end
            if (i < RN_I && bad_plan[i]) exp_mism = 1'b1;
        end
        exp_done  = !exp_err;
        exp_total = exp_q.size();
        for (int i = 0; i < 256; i++) tries[i] = 0;
    endtask

    task automatic clearPlans();
        for (int i = 0; i < 256; i++) begin
            nack_plan[i] = 0;
            bad_plan[i]  = 1'b0;
            bad_val[i]   = ~lut_mem[i][15:0];
        end
    endtask

    task automatic setDirectedLut();
        for (int i = 0; i < 256; i++) lut_mem[i] = 24'($urandom);
        lut_mem[0] = {8'h0A, 16'h00B5};
        lut_mem[1] = {8'h0B, 16'h2145};
        lut_mem[2] = {8'h0C, 16'h0001};
        lut_mem[3] = {8'h0C, 16'h0000};
        lut_mem[4] = {8'h0D, 16'h0000};
        lut_mem[5] = {8'h0F, 16'h0001};
        lut_mem[6] = {8'h70, 16'h0003};
        clearPlans();
    endtask

    task automatic randomPlans(input bit clean);
        for (int i = 0; i < 256; i++) begin
            int r;
            lut_mem[i] = 24'($urandom);
            r = int'($urandom_range(0, 99));
            nack_plan[i] = clean ? 0 : (r < 70) ? 0 : (r < 85) ? 1 : (r < 92) ? 2 : (r < 96) ? 3 : 50;
            bad_plan[i]  = ($urandom_range(0, 3) == 0);
            bad_val[i]   = lut_mem[i][15:0] ^ 16'($urandom_range(1, 65535));
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        #1;
        checkOutput("rst_req",   i2c_req,     0);
        checkOutput("rst_busy",  cfg_busy,    0);
        checkOutput("rst_done",  cfg_done,    0);
        checkOutput("rst_err",   cfg_err,     0);
        checkOutput("rst_mism",  id_mismatch, 0);
        checkOutput("rst_index", lut_index,   0);
        checkOutput("rst_addr",  {i2c_rw, i2c_addr, i2c_wdata}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Start a run either from reset or with a cfg_start pulse (DUT idle)
    task automatic applyStimulus(input bit use_start);
        buildModel(int'(lut_size));
        rise_base = rise_times.size();
        if (!use_start) begin
            doReset();
            base_cyc = 0;
        end else begin
            @(negedge clk);
            cfg_start = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
            base_cyc  = cyc;
            checkOutput("start_clr_done",  cfg_done,    0);
            checkOutput("start_clr_err",   cfg_err,     0);
            checkOutput("start_clr_mism",  id_mismatch, 0);
            checkOutput("start_clr_index", lut_index,   0);
            checkOutput("start_busy",      cfg_busy,    1);
        end
    endtask

    task automatic waitAndCheck(input string name);
        int n;
        int limit;
        int rc;
        n     = 0;
        limit = 200 + INIT_I + (exp_total + 2) * (GAP_I + 12);
        do begin
            @(negedge clk);
            n++;
        end while ((cfg_busy !== 1'b0 || n < 3) && n < limit);
        if (n >= limit) checkOutput({name, "_finish_in_budget"}, 0, 1);
        checkOutput({name, "_done"},      cfg_done,    exp_done);
        checkOutput({name, "_err"},       cfg_err,     exp_err);
        checkOutput({name, "_mismatch"},  id_mismatch, exp_mism);
        checkOutput({name, "_index"},     lut_index,   exp_index);
        checkOutput({name, "_busy"},      cfg_busy,    0);
        checkOutput({name, "_pending"},   exp_q.size(), 0);
        checkOutput({name, "_txn_count"}, rise_times.size() - rise_base, exp_total);
        rc = rise_times.size();
        repeat (3 * GAP_I + 10) @(negedge clk);
        checkOutput({name, "_no_req_after"}, rise_times.size(), rc);
    endtask

    task automatic checkFirstReq();
        if (rise_times.size() > rise_base)
            checkOutput("first_req_cycle", rise_times[rise_base] - base_cyc + 1, INIT_I + 2);
        else
            checkOutput("first_req_seen", 0, 1);
    endtask

    // Cycle counter, zeroed while in reset
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) cyc = 0;
            else        cyc = cyc + 1;
        end
    end

    // Monitor: request rise times, low time between requests, cfg_done rise
    initial begin
        mon_prev = 0; mon_has_prev = 0; mon_dprev = 0; mon_low = 0; done_rise_cyc = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev = 0; mon_has_prev = 0; mon_dprev = 0;
            end else begin
                if (i2c_req && !mon_prev) begin
                    rise_times.push_back(cyc);
                    if (mon_has_prev) checkOutput("gap_low_cycles", mon_low >= GAP_I + 1, 1);
                end
                if (!i2c_req && mon_prev) begin
                    mon_has_prev = 1;
                    mon_low      = 0;
                end
                if (!i2c_req) mon_low++;
                if (cfg_done && !mon_dprev) done_rise_cyc = cyc;
                mon_dprev = cfg_done;
                mon_prev  = i2c_req;
            end
        end
    end

    task automatic respond();
        txn_t t;
        int   lat;
        bit   aborted;
        bit   nk;
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_req", 1, 0);
            t.idx = int'(lut_index); t.rw = i2c_rw; t.addr = i2c_addr; t.wdata = i2c_wdata;
        end else begin
            t = exp_q.pop_front();
            checkOutput("txn_index", lut_index, t.idx);
            checkOutput("txn_rw",    i2c_rw,    t.rw);
            checkOutput("txn_addr",  i2c_addr,  t.addr);
            checkOutput("txn_wdata", i2c_wdata, t.wdata);
        end
        lat     = int'($urandom_range(1, 4));
        aborted = 0;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            if (!rst_n) aborted = 1;
        end
        if (aborted || !rst_n) return;
        checkOutput("req_held",  i2c_req,  1);
        checkOutput("addr_held", i2c_addr, t.addr);
        tries[t.idx]++;
        nk        = (tries[t.idx] <= nack_plan[t.idx]);
        i2c_nack  = nk;
        i2c_rdata = bad_plan[t.idx] ? bad_val[t.idx] : lut_mem[t.idx][15:0];
        i2c_done  = 1'b1;
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        if (rst_n) checkOutput("req_drop", i2c_req, 0);
    endtask

    // I2C slave model; optionally injects completion pulses with no request
    initial begin
        i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 16'd0;
        forever begin
            @(negedge clk);
            if (rst_n && i2c_req) begin
                respond();
            end else if (rst_n && stray_en && $urandom_range(0, 15) == 0) begin
                i2c_done  = 1'b1;
                i2c_nack  = 1'($urandom_range(0, 1));
                i2c_rdata = 16'($urandom);
                @(negedge clk);
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; cfg_start = 1'b0; lut_size = 8'd0; stray_en = 1'b0;
        setDirectedLut();

        // Clean run: 2 reads then 5 writes
        lut_size = 8'd7;
        applyStimulus(1'b0);
        waitAndCheck("basic");
        checkFirstReq();

        // Read at index 1 returns wrong data
        setDirectedLut();
        bad_plan[1] = 1'b1;
        bad_val[1]  = 16'h1324;
        applyStimulus(1'b1);
        waitAndCheck("mismatch");
        checkFirstReq();

        // Two NACKs on index 3, then ACK
        setDirectedLut();
        nack_plan[3] = 2;
        applyStimulus(1'b1);
        waitAndCheck("retry");
        checkOutput("idx3_attempts", tries[3], 3);

        // Permanent NACK on index 4
        setDirectedLut();
        nack_plan[4] = 1000;
        applyStimulus(1'b1);
        waitAndCheck("abort");
        checkOutput("idx4_attempts", tries[4], 4);

        // Empty LUT, then restart with an ignored start pulse during INIT
        lut_size = 8'd0;
        applyStimulus(1'b0);
        waitAndCheck("empty");
        checkOutput("empty_done_cycle", done_rise_cyc - base_cyc + 1, INIT_I + 2);
        applyStimulus(1'b1);
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        waitAndCheck("empty_restart");
        checkOutput("restart_done_cycle", done_rise_cyc - base_cyc + 1, INIT_I + 2);

        // Asynchronous reset during a write, then full rerun
        setDirectedLut();
        lut_size = 8'd7;
        applyStimulus(1'b0);
        n = 0;
        while (!(i2c_req === 1'b1 && i2c_rw === 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) checkOutput("write_seen", 0, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_req_drop", i2c_req,   0);
        checkOutput("async_index",    lut_index, 0);
        checkOutput("async_busy",     cfg_busy,  0);
        applyStimulus(1'b0);
        waitAndCheck("rerun");
        checkFirstReq();

        // Randomized runs, including a full 255-entry LUT
        stray_en = 1'b1;
        for (int it = 0; it < 12; it++) begin
            randomPlans(it == 5);
            lut_size = (it == 5) ? 8'd255 : 8'($urandom_range(0, 20));
            applyStimulus(it[0]);
            waitAndCheck($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
- Walks a camera-sensor configuration LUT from index 0 to lut_size-1 and issues one I2C transaction per entry to the shared I2C master.
- The first READ_NUM entries are read-and-compare checks (lock code, chip version); all later entries are register writes.
- Inserts a power-up delay and a fixed inter-transaction gap, which covers the sensor's post-reset minimum clock requirement.
- Retries NACKed transfers, then reports done or error to the system. It sits between the config LUT and the I2C bit-level master.

Parameters:
- INIT_DLY, 24'd1_000_000, clk cycles waited after reset or restart before the first transaction (20 ms at 50 MHz).
- GAP_DLY, 16'd100, idle clk cycles after each completed transaction (must be ≥15).
- READ_NUM, 8'd2, number of leading LUT entries treated as reads.
- MAX_RETRY, 4'd3, retries per entry after a NACK before aborting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse; restarts the full sequence when not busy
- lut_index  out  8  LUT address
- lut_data  in  24  {reg_addr[23:16], data[15:0]}, combinational from lut_index
- lut_size  in  8  number of valid LUT entries
- i2c_req  out  1  transaction request, level
- i2c_rw  out  1  1=read, 0=write
- i2c_addr  out  8  register address
- i2c_wdata  out  16  write data
- i2c_done  in  1  one-cycle completion pulse from master
- i2c_nack  in  1  valid with i2c_done; 1=slave NACK
- i2c_rdata  in  16  read data, valid with i2c_done
- cfg_busy  out  1  sequence in progress
- cfg_done  out  1  sticky; all entries completed
- cfg_err  out  1  sticky; aborted on retry exhaustion
- id_mismatch  out  1  sticky; some read returned ≠ lut_data[15:0]

Behaviour:
- Reset values: all outputs 0, lut_index=0, state INIT. Asynchronous reset mid-transaction drops i2c_req immediately; the master must tolerate that.
- Sequence starts automatically out of reset.
- States:
  - INIT: count INIT_DLY cycles, then go to LOAD. cfg_busy=1 from reset exit.
  - LOAD: if lut_index ≥ lut_size, go to DONE. Otherwise register i2c_addr/i2c_wdata from lut_data, set i2c_rw=(lut_index<READ_NUM), go to REQ. Adds one cycle of LUT settle.
  - REQ: i2c_req=1; i2c_rw/i2c_addr/i2c_wdata held stable. Wait for i2c_done.
  - On i2c_done with nack=0:
    - read entry: compare i2c_rdata to captured expected data; mismatch sets id_mismatch; continue either way.
    - drop i2c_req the same edge; retry counter=0; go to GAP.
  - On i2c_done with nack=1:
    - retry < MAX_RETRY: retry++, drop i2c_req, go to GAP; same index is reissued.
    - otherwise: go to ERR.
  - GAP: count GAP_DLY cycles. Then lut_index++ (only if the last transfer succeeded) and go to LOAD.
  - DONE: cfg_done=1, cfg_busy=0, lut_index holds lut_size.
  - ERR: cfg_err=1, cfg_busy=0, lut_index holds the failing entry.
- Timing:
  - i2c_req rises 2 cycles after INIT completes (LOAD, then REQ).
  - i2c_req deasserts the cycle after i2c_done is sampled.
  - Between successive requests: ≥ GAP_DLY+1 cycles low.
- Boundary conditions:
  - lut_size=0: go straight from INIT to LOAD to DONE with no I2C traffic.
  - lut_size ≤ READ_NUM: reads only.
  - i2c_done outside REQ: ignored.
  - cfg_start:
    - honoured only in DONE or ERR. It clears cfg_done, cfg_err and id_mismatch, sets lut_index=0, and reloads INIT.
    - ignored while busy.
  - lut_index is 8-bit; lut_size=255 max, so the increment never wraps past 255 because the LOAD compare stops it.
  - Counters: INIT 24-bit, GAP 16-bit; compare against param-1, no off-by-one.

Decomposition:
- Shared package cfg_seq_pkg:
  - state encoding (INIT, LOAD, REQ, GAP, DONE, ERR)
  - LUT field slice constants: ADDR_MSB=23, ADDR_LSB=16, DATA_MSB=15
  - default delay constants
- One natural sub-module: cfg_delay_cnt, a loadable down-counter with a zero flag, instanced for INIT and GAP (or one shared instance, reloaded per state).

Test Plan:
- Reset, INIT_DLY=10, GAP_DLY=4, lut_size=7, READ_NUM=2, model ACKs in 3 cycles, reads return matching data -> i2c_req rises at cycle 12. Exactly 2 reads then 5 writes in order: (0x0C,0x0001), (0x0C,0x0000), (0x0D,0x0000), (0x0F,0x0001), (0x70,0x0003). cfg_done=1, id_mismatch=0.
- Same setup, but the read at index 1 returns 0x1324 -> id_mismatch=1, all 7 transactions still issued, cfg_done=1, cfg_err=0.
- NACK on index 3 twice, then ACK with MAX_RETRY=3 -> index 3 issued 3 times, each separated by ≥5 idle cycles; sequence completes with cfg_done=1.
- NACK on index 4 permanently -> 4 attempts total, then cfg_err=1, cfg_busy=0, lut_index=4, no further i2c_req.
- lut_size=0 -> no i2c_req ever; cfg_done=1 at cycle INIT_DLY+2. Then a cfg_start pulse clears cfg_done and reruns INIT; a cfg_start pulse during INIT is ignored.
- rst_n low while i2c_req=1 mid-write -> i2c_req=0 asynchronously. After release, a full rerun from index 0 with outputs at reset values.
